serial_adder: RTL

- Bit-serial N-bit adder built around the team's single-bit half-adder sum/carry logic plus a registered carry.
- Accepts two WIDTH-bit operands with a start strobe and processes one bit per clock, LSB first.
- Returns the WIDTH-bit sum and final carry with a one-cycle done pulse.
- Sits downstream of operand capture and upstream of any result consumer; it is the area-lean alternative to a ripple adder.

---
 rtl/serial_adder_if.sv | 24 ++
 rtl/serial_adder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder: requester drives start and operands,
// the adder returns busy, the done pulse and the registered sum/carry.
interface serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             carry_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             carry;

   modport master (
      output start, a, b, carry_in,
      input  busy, done, sum, carry
   );

   modport slave (
      input  start, a, b, carry_in,
      output busy, done, sum, carry
   );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder step per clock, LSB first, built from two half-adder
// stages and a registered carry. Result and final carry load together with a done pulse.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input logic           clk,
   input logic           rst_n,
   serial_adder_if.slave bus
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [WIDTH-1:0] a_sr_r;
   logic [WIDTH-1:0] b_sr_r;
   logic [WIDTH-1:0] res_sr_r;
   logic [WIDTH-1:0] res_next_s;
   logic [WIDTH-1:0] sum_r;
   logic [CNT_W-1:0] cnt_r;
   logic             c_r;
   logic             carry_r;
   logic             busy_r;
   logic             done_r;
   logic             busy_nxt_s;
   logic             done_nxt_s;
   logic             hs1_s;
   logic             hc1_s;
   logic             bit_sum_s;
   logic             c_next_s;
   logic             last_bit_s;

   function automatic logic ha_sum(input logic x, input logic y);
      return x ^ y;
   endfunction

   function automatic logic ha_carry(input logic x, input logic y);
      return x & y;
   endfunction

   // Full-adder bit from two half-adder stages; the two carries cannot both be set.
   always_comb begin
      hs1_s      = ha_sum(a_sr_r[0], b_sr_r[0]);
      hc1_s      = ha_carry(a_sr_r[0], b_sr_r[0]);
      bit_sum_s  = ha_sum(hs1_s, c_r);
      c_next_s   = hc1_s | ha_carry(hs1_s, c_r);
      last_bit_s = (cnt_r == CNT_LAST);
   end

   generate
      if (WIDTH == 1) begin : g_res_w1
         assign res_next_s = bit_sum_s;
      end else begin : g_res_wn
         assign res_next_s = {bit_sum_s, res_sr_r[WIDTH-1:1]};
      end
   endgenerate

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode; start is only looked at in IDLE.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               state_nxt_s = ADD;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ADD: begin
            if (last_bit_s) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = ADD;
            end
         end
         DONE:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Flag decode from the upcoming state so busy/done can be registered without lag.
   always_comb begin
      busy_nxt_s = 1'b0;
      done_nxt_s = 1'b0;
      case (state_nxt_s)
         IDLE: begin
            busy_nxt_s = 1'b0;
            done_nxt_s = 1'b0;
         end
         ADD: begin
            busy_nxt_s = 1'b1;
            done_nxt_s = 1'b0;
         end
         DONE: begin
            busy_nxt_s = 1'b1;
            done_nxt_s = 1'b1;
         end
         default: begin
            busy_nxt_s = 1'b0;
            done_nxt_s = 1'b0;
         end
      endcase
   end

   // Registered status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         busy_r <= busy_nxt_s;
         done_r <= done_nxt_s;
      end
   end

   // Operand capture, serial shifting and final result load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr_r   <= '0;
         b_sr_r   <= '0;
         res_sr_r <= '0;
         c_r      <= 1'b0;
         cnt_r    <= '0;
         sum_r    <= '0;
         carry_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.start) begin
                  a_sr_r <= bus.a;
                  b_sr_r <= bus.b;
                  c_r    <= bus.carry_in;
                  cnt_r  <= '0;
               end
            end
            ADD: begin
               a_sr_r   <= a_sr_r >> 1'b1;
               b_sr_r   <= b_sr_r >> 1'b1;
               res_sr_r <= res_next_s;
               c_r      <= c_next_s;
               cnt_r    <= cnt_r + CNT_ONE;
               if (last_bit_s) begin
                  sum_r   <= res_next_s;
                  carry_r <= c_next_s;
               end
            end
            DONE: begin
               cnt_r <= '0;
            end
            default: begin
               cnt_r <= '0;
            end
         endcase
      end
   end

   assign bus.busy  = busy_r;
   assign bus.done  = done_r;
   assign bus.sum   = sum_r;
   assign bus.carry = carry_r;

endmodule
